fsm_cfg_bridge: RTL

//  Memory-mapped slave on the PicoRV32 native memory bus; the stage directly upstream of fsm_overlay.

---
 rtl/fsm_cfg_bridge_pkg.sv | 36 +++
 rtl/fsm_cfg_bridge_if.sv | 22 ++
 rtl/fsm_cfg_bridge_trans_counter.sv | 42 ++++
 rtl/fsm_cfg_bridge.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_cfg_bridge_pkg.sv
// Shared definitions for the fsm_overlay configuration bridge: register map,
// CTRL/STATUS bit positions, bus widths and FSM state encodings.
package fsm_overlay_pkg;

  localparam int BUS_ADDR_BITS = 5;
  localparam int BUS_DATA_BITS = 32;

  // Register index is mem_addr[4:2]
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_CFG    = 3'd1;
  localparam logic [2:0] REG_INPUT  = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_MATCH  = 3'd4;
  localparam logic [2:0] REG_TCNT   = 3'd5;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_COMMIT    = 1;
  localparam int CTRL_SOFT_RST  = 2;
  localparam int CTRL_IRQ_EN    = 3;

  localparam int STAT_MATCH     = 0;
  localparam int STAT_PENDING   = 1;
  localparam int STAT_SOFT_RST  = 2;
  localparam int STAT_STATE_LSB = 8;

  typedef enum logic {
    CMT_IDLE    = 1'b0,
    CMT_PENDING = 1'b1
  } commit_state_t;

  typedef enum logic {
    SRST_IDLE   = 1'b0,
    SRST_ACTIVE = 1'b1
  } srst_state_t;

endpackage

// File: rtl/fsm_cfg_bridge_if.sv
// PicoRV32 native memory bus as seen by the bridge (decode hit included).
interface fsm_cfg_bridge_if;
  import fsm_overlay_pkg::*;

  logic                     mem_valid;
  logic                     mem_sel;
  logic [BUS_ADDR_BITS-1:0] mem_addr;
  logic [BUS_DATA_BITS-1:0] mem_wdata;
  logic [3:0]               mem_wstrb;
  logic                     mem_ready;
  logic [BUS_DATA_BITS-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_sel, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_sel, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/fsm_cfg_bridge_trans_counter.sv
// Saturating counter of value changes on a sampled bus; clear beats increment.
module fsm_trans_counter #(
  parameter int DATA_BITS = 4,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] sample,
  input  logic                 enable,
  input  logic                 clear,
  output logic [CNT_BITS-1:0]  count
);

  logic [DATA_BITS-1:0] sample_reg;
  logic [CNT_BITS-1:0]  count_reg;
  logic [CNT_BITS-1:0]  count_next;
  logic                 change;

  assign change = (sample != sample_reg);

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (change && enable && (count_reg != '1)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_reg <= '0;
      count_reg  <= '0;
    end else begin
      sample_reg <= sample;
      count_reg  <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fsm_cfg_bridge.sv
// CPU-facing bridge for fsm_overlay: shadowed config with explicit commit,
// timed soft reset, transition counting and a sticky state-match interrupt.
module fsm_cfg_bridge
  import fsm_overlay_pkg::*;
#(
  parameter int STATE_BITS = 4,
  parameter int INPUT_BITS = 8,
  parameter int CNT_BITS   = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fsm_cfg_bridge_if.slave       bus,
  input  logic [STATE_BITS-1:0] fsm_state,
  output logic [STATE_BITS-1:0] fsm_config,
  output logic [INPUT_BITS-1:0] fsm_input,
  output logic                  fsm_rst_n,
  output logic                  irq
);

  localparam int                 RC_BITS = $clog2(RST_CYCLES + 1);
  localparam logic [RC_BITS-1:0] RC_LOAD = RC_BITS'(RST_CYCLES);
  localparam logic [RC_BITS-1:0] RC_LAST = RC_BITS'(1);

  logic                  ready_reg;
  logic [31:0]           rdata_reg;
  logic [31:0]           rdata_next;
  logic                  rst_done_reg;

  logic                  en_reg;
  logic                  irq_en_reg;
  logic [STATE_BITS-1:0] cfg_reg;
  logic [INPUT_BITS-1:0] input_reg;
  logic [STATE_BITS-1:0] match_reg;
  logic [STATE_BITS-1:0] fsm_config_reg;
  logic                  match_flag_reg;
  logic                  match_flag_next;

  commit_state_t         cmt_reg, cmt_next;
  logic                  cfg_apply;
  srst_state_t           srst_reg, srst_next;
  logic [RC_BITS-1:0]    rcnt_reg, rcnt_next;
  logic                  soft_active;

  logic                  req;
  logic                  wr;
  logic                  rd;
  logic [2:0]            reg_idx;
  logic [31:0]           byte_mask;
  logic                  ctrl_byte0_wr;
  logic                  commit_wr;
  logic                  soft_wr;
  logic                  status_w1c;
  logic                  tcnt_clr;
  logic                  match_set;
  logic [CNT_BITS-1:0]   tcnt;
  logic                  unused_addr;

  function automatic logic [31:0] merge_word(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // A request is never re-sampled in its own ack cycle, so a held mem_valid
  // cannot produce a second transfer.
  assign req         = bus.mem_valid & bus.mem_sel & ~ready_reg;
  assign wr          = req & (|bus.mem_wstrb);
  assign rd          = req & ~(|bus.mem_wstrb);
  assign reg_idx     = bus.mem_addr[4:2];
  assign unused_addr = ^bus.mem_addr[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_mask
      assign byte_mask[8*gi +: 8] = {8{bus.mem_wstrb[gi]}};
    end
  endgenerate

  assign ctrl_byte0_wr = wr & (reg_idx == REG_CTRL) & bus.mem_wstrb[0];
  assign commit_wr     = ctrl_byte0_wr & bus.mem_wdata[CTRL_COMMIT];
  assign soft_wr       = ctrl_byte0_wr & bus.mem_wdata[CTRL_SOFT_RST];
  assign status_w1c    = wr & (reg_idx == REG_STATUS) & bus.mem_wstrb[0]
                         & bus.mem_wdata[STAT_MATCH];
  assign tcnt_clr      = wr & (reg_idx == REG_TCNT);

  assign soft_active   = (srst_reg == SRST_ACTIVE);

  // Commit FSM: config is held back while the overlay sits in soft reset
  always_comb begin
    cmt_next  = cmt_reg;
    cfg_apply = 1'b0;
    if (cmt_reg == CMT_PENDING && !soft_active) begin
      cfg_apply = 1'b1;
      cmt_next  = CMT_IDLE;
    end
    if (commit_wr) begin
      cmt_next = CMT_PENDING;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmt_reg <= CMT_IDLE;
    end else begin
      cmt_reg <= cmt_next;
    end
  end

  // Soft-reset FSM: a new request while active reloads the full pulse length
  always_comb begin
    srst_next = srst_reg;
    rcnt_next = rcnt_reg;
    if (soft_wr) begin
      srst_next = SRST_ACTIVE;
      rcnt_next = RC_LOAD;
    end else if (srst_reg == SRST_ACTIVE) begin
      if (rcnt_reg == RC_LAST) begin
        srst_next = SRST_IDLE;
        rcnt_next = '0;
      end else begin
        rcnt_next = rcnt_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srst_reg <= SRST_IDLE;
      rcnt_reg <= '0;
    end else begin
      srst_reg <= srst_next;
      rcnt_reg <= rcnt_next;
    end
  end

  assign match_set       = en_reg & (fsm_state == match_reg) & ~soft_active;
  assign match_flag_next = match_set | (match_flag_reg & ~status_w1c);

  always_comb begin
    rdata_next = '0;
    if (rd) begin
      case (reg_idx)
        REG_CTRL: begin
          rdata_next[CTRL_EN]     = en_reg;
          rdata_next[CTRL_IRQ_EN] = irq_en_reg;
        end
        REG_CFG:   rdata_next[STATE_BITS-1:0] = cfg_reg;
        REG_INPUT: rdata_next[INPUT_BITS-1:0] = input_reg;
        REG_STATUS: begin
          rdata_next[STAT_MATCH]                     = match_flag_reg;
          rdata_next[STAT_PENDING]                   = (cmt_reg == CMT_PENDING);
          rdata_next[STAT_SOFT_RST]                  = soft_active;
          rdata_next[STAT_STATE_LSB +: STATE_BITS]   = fsm_state;
        end
        REG_MATCH: rdata_next[STATE_BITS-1:0] = match_reg;
        REG_TCNT:  rdata_next[CNT_BITS-1:0]   = tcnt;
        default:   rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_reg      <= 1'b0;
      rdata_reg      <= '0;
      rst_done_reg   <= 1'b0;
      en_reg         <= 1'b0;
      irq_en_reg     <= 1'b0;
      cfg_reg        <= '0;
      input_reg      <= '0;
      match_reg      <= '0;
      fsm_config_reg <= '0;
      match_flag_reg <= 1'b0;
    end else begin
      ready_reg      <= req;
      rdata_reg      <= rdata_next;
      rst_done_reg   <= 1'b1;
      match_flag_reg <= match_flag_next;
      if (cfg_apply) begin
        fsm_config_reg <= cfg_reg;
      end
      if (wr) begin
        case (reg_idx)
          REG_CTRL: begin
            if (bus.mem_wstrb[0]) begin
              en_reg     <= bus.mem_wdata[CTRL_EN];
              irq_en_reg <= bus.mem_wdata[CTRL_IRQ_EN];
            end
          end
          REG_CFG:   cfg_reg   <= STATE_BITS'(merge_word(32'(cfg_reg), bus.mem_wdata, byte_mask));
          REG_INPUT: input_reg <= INPUT_BITS'(merge_word(32'(input_reg), bus.mem_wdata, byte_mask));
          REG_MATCH: match_reg <= STATE_BITS'(merge_word(32'(match_reg), bus.mem_wdata, byte_mask));
          default: ;
        endcase
      end
    end
  end

  fsm_trans_counter #(
    .DATA_BITS (STATE_BITS),
    .CNT_BITS  (CNT_BITS)
  ) u_trans_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (fsm_state),
    .enable (~soft_active),
    .clear  (tcnt_clr),
    .count  (tcnt)
  );

  assign bus.mem_ready = ready_reg;
  assign bus.mem_rdata = rdata_reg;
  assign fsm_config    = fsm_config_reg;
  assign fsm_input     = en_reg ? input_reg : '0;
  // Deassertion is synchronous via rst_done_reg; assertion follows rst_n at once
  assign fsm_rst_n     = rst_n & rst_done_reg & ~soft_active;
  assign irq           = match_flag_reg & irq_en_reg;

endmodule
